// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave with 2^ADDR_WIDTH x 32-bit word memory and fixed wait states.
// Latency: WAIT_STATES low cycles per OKAY data phase; 2-cycle ERROR response for unaligned accesses.
// Backpressure: HREADYOUT held low during wait/first error cycle; new address phases taken only when HREADYOUT is high.
module ahb_slave_mem #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  localparam int             DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0]     WS    = 4'(WAIT_STATES);

  state_t                  state;
  state_t                  state_nxt;
  logic [3:0]              cnt;
  logic [3:0]              cnt_nxt;
  logic                    wr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    unal_q;
  logic [31:0]             mem [0:DEPTH-1];

  logic                    can_accept;
  logic                    accept;
  logic                    unal_in;
  logic                    fwd;
  logic                    commit;
  logic                    wait_last;
  logic [ADDR_WIDTH-1:0]   addr_in;

  // Upper address bits alias onto the same words; HTRANS[0] only separates SEQ from NONSEQ.
  logic unused_ok;
  assign unused_ok = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

  // A new address phase can only be taken while this slave is not stalling the bus.
  assign can_accept = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
  assign accept     = can_accept && HSEL && HREADY && HTRANS[1];
  assign addr_in    = HADDR[ADDR_WIDTH+1:2];
  assign unal_in    = (HADDR[1:0] != 2'b00);
  // Write in its data phase targets the word the new read wants: bypass the array.
  assign fwd        = (state == ST_DATA) && wr_q && (addr_q == addr_in);
  assign commit     = (state == ST_DATA) && wr_q && !unal_q;
  assign wait_last  = (state == ST_WAIT) && (cnt <= 4'd1);

  // Next-state, wait counter and bus response decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state)
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        cnt_nxt   = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_nxt = ST_DATA;
          cnt_nxt   = 4'd0;
        end
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP = 1'b1;
      end
      default: ;
    endcase
    if (can_accept) begin
      if (accept) begin
        if (unal_in) begin
          state_nxt = ST_ERR1;
        end else if (WAIT_STATES > 0) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = WS;
        end else begin
          state_nxt = ST_DATA;
        end
      end else begin
        state_nxt = ST_IDLE;
      end
    end
  end

  // State and wait counter registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Capture the address-phase attributes of each accepted transfer.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_q   <= 1'b0;
      addr_q <= '0;
      unal_q <= 1'b0;
    end else if (accept) begin
      wr_q   <= HWRITE;
      addr_q <= addr_in;
      unal_q <= unal_in;
    end
  end

  // Read data is loaded on entry to the data phase and held until the next read.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HRDATA <= 32'd0;
    end else if (accept && !HWRITE) begin
      if (unal_in) begin
        HRDATA <= 32'd0;
      end else if (WAIT_STATES == 0) begin
        HRDATA <= fwd ? HWDATA : mem[addr_in];
      end
    end else if (wait_last && !wr_q) begin
      HRDATA <= mem[addr_q];
    end
  end

  // Storage array is never reset; a write lands at the edge closing its data phase.
  always_ff @(posedge HCLK) begin
    if (commit) begin
      mem[addr_q] <= HWDATA;
    end
  end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: three instances (0, 2 and 4 wait states) on a shared bus.
// Driver issues pipelined AHB transfers and queues expected responses from a word-array model.
// A negedge monitor pops the queue whenever a data phase completes and compares the response.
module tb_ahb_slave_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel [3];
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        hreadyout [3];
  logic        hresp [3];
  logic [31:0] hrdata [3];

  always #5 clk = ~clk;

  ahb_slave_mem #(.ADDR_WIDTH(8), .WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hreadyout[0]),
    .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0]));

  ahb_slave_mem #(.ADDR_WIDTH(8), .WAIT_STATES(2)) u_dut1 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hreadyout[1]),
    .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1]));

  ahb_slave_mem #(.ADDR_WIDTH(8), .WAIT_STATES(4)) u_dut2 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[2]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hreadyout[2]),
    .HREADYOUT(hreadyout[2]), .HRESP(hresp[2]), .HRDATA(hrdata[2]));

  typedef struct packed {
    logic [1:0]  dut;
    logic        rd;
    logic        chk;
    logic [31:0] data;
    logic        resp;
    logic [4:0]  waits;
  } exp_t;

  exp_t        sbq [$];
  logic [31:0] ref_mem [3][256];
  bit          ref_vld [3][256];
  int          checks = 0;
  int          errors = 0;

  bit          dph [3];
  int          waits [3];
  bit          resp_low [3];

  function automatic int ws_of(input int k);
    return k * 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One AHB address phase to slave k; returns one edge after it is taken, with HWDATA set for its data phase.
  task automatic bus_xfer(input int k, input bit sel, input logic [1:0] tr, input bit wr,
                          input logic [31:0] a, input logic [31:0] wd);
    int   w;
    int   n;
    exp_t e;
    for (int j = 0; j < 3; j++) hsel[j] = 1'b0;
    hsel[k] = sel;
    htrans  = tr;
    hwrite  = wr;
    haddr   = a;
    if (sel && tr[1]) begin
      w       = int'(a[9:2]);
      e.dut   = 2'(k);
      e.rd    = !wr;
      e.resp  = (a[1:0] != 2'b00);
      e.waits = e.resp ? 5'd1 : 5'(ws_of(k));
      e.chk   = 1'b0;
      e.data  = 32'd0;
      if (e.resp) begin
        e.chk = !wr;
      end else if (wr) begin
        ref_mem[k][w] = wd;
        ref_vld[k][w] = 1'b1;
      end else begin
        e.chk  = ref_vld[k][w];
        e.data = ref_mem[k][w];
      end
      sbq.push_back(e);
    end
    n = 0;
    forever begin
      @(negedge clk);
      if (hreadyout[k]) break;
      n++;
      if (n > 40) begin
        checks++;
        errors++;
        $display("FAIL timeout dut%0d: HREADYOUT stuck low, required high within 40 cycles", k);
        break;
      end
    end
    @(posedge clk);
    #1;
    hwdata = wd;
  endtask

  task automatic idle(input int k);
    bus_xfer(k, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic check_zero_wait(input int k, input string name);
    @(negedge clk);
    chk({name, "_hreadyout"}, 32'(hreadyout[k]), 32'd1);
    chk({name, "_hresp"}, 32'(hresp[k]), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: tracks each slave's data phase and checks it when HREADYOUT closes it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int k = 0; k < 3; k++) dph[k] = 1'b0;
        sbq.delete();
      end else begin
        for (int k = 0; k < 3; k++) begin
          if (dph[k]) begin
            if (!hreadyout[k]) begin
              waits[k]++;
              resp_low[k] = resp_low[k] | hresp[k];
            end else begin
              if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty dut%0d: response seen, none expected", k);
              end else begin
                e = sbq.pop_front();
                chk("sb_dut", 32'(k), 32'(e.dut));
                chk("wait_cycles", 32'(waits[k]), 32'(e.waits));
                chk("hresp", 32'(hresp[k]), 32'(e.resp));
                if (e.waits != 0) chk("hresp_stall", 32'(resp_low[k]), 32'(e.resp));
                if (e.rd && e.chk) chk("hrdata", hrdata[k], e.data);
              end
              dph[k] = 1'b0;
            end
          end
          if (hsel[k] && htrans[1] && hreadyout[k]) begin
            dph[k]      = 1'b1;
            waits[k]    = 0;
            resp_low[k] = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] up;
    logic [7:0]  word;
    logic [31:0] a;
    logic [1:0]  tr;
    int          t;
    rst_n  = 1'b0;
    haddr  = 32'd0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hwdata = 32'd0;
    for (int k = 0; k < 3; k++) begin
      hsel[k] = 1'b0;
      dph[k]  = 1'b0;
      for (int w = 0; w < 256; w++) ref_vld[k][w] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_hreadyout", 32'(hreadyout[k]), 32'd1);
      chk("rst_hresp", 32'(hresp[k]), 32'd0);
      chk("rst_hrdata", hrdata[k], 32'd0);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Zero wait states: back-to-back writes and reads.
    bus_xfer(0, 1, 2'b10, 1, 32'h0000_0010, 32'h1111_1111);
    bus_xfer(0, 1, 2'b11, 1, 32'h0000_0014, 32'h2222_2222);
    bus_xfer(0, 1, 2'b10, 0, 32'h0000_0010, 32'h0);
    bus_xfer(0, 1, 2'b11, 0, 32'h0000_0014, 32'h0);
    // Write immediately followed by a read of the same word.
    bus_xfer(0, 1, 2'b10, 1, 32'h0000_0020, 32'h5555_5555);
    bus_xfer(0, 1, 2'b10, 0, 32'h0000_0020, 32'h0);
    // Unaligned read errors, then a normal read.
    bus_xfer(0, 1, 2'b10, 0, 32'h0000_0013, 32'h0);
    bus_xfer(0, 1, 2'b10, 0, 32'h0000_0010, 32'h0);
    idle(0);
    // Unselected and IDLE write attempts leave memory alone.
    bus_xfer(0, 0, 2'b10, 1, 32'h0000_0010, 32'hDEAD_BEEF);
    check_zero_wait(0, "unsel");
    bus_xfer(0, 1, 2'b00, 1, 32'h0000_0010, 32'hDEAD_BEEF);
    check_zero_wait(0, "idle_trans");
    bus_xfer(0, 1, 2'b01, 1, 32'h0000_0010, 32'hDEAD_BEEF);
    check_zero_wait(0, "busy_trans");
    bus_xfer(0, 1, 2'b10, 0, 32'h0000_0010, 32'h0);
    idle(0);

    // Two wait states.
    bus_xfer(1, 1, 2'b10, 1, 32'h0000_0010, 32'h1111_1111);
    idle(1);
    bus_xfer(1, 1, 2'b10, 0, 32'h0000_0010, 32'h0);
    bus_xfer(1, 1, 2'b10, 1, 32'h0000_0020, 32'h5555_5555);
    bus_xfer(1, 1, 2'b10, 0, 32'h0000_0020, 32'h0);
    bus_xfer(1, 1, 2'b10, 0, 32'h0000_0013, 32'h0);
    idle(1);

    // Randomized traffic on the 0- and 2-wait-state slaves, with address aliasing.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 150; i++) begin
        up   = $urandom;
        word = 8'($urandom_range(0, 7));
        a    = {up[21:0], word, 2'b00};
        if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
        t = $urandom_range(0, 7);
        tr = (t == 0) ? 2'b00 : (t == 1) ? 2'b01 : (t < 5) ? 2'b10 : 2'b11;
        bus_xfer(k, $urandom_range(0, 15) != 0, tr, $urandom_range(0, 1) == 1, a, $urandom);
      end
      idle(k);
    end

    // Four wait states: reset during the wait of a write aborts it.
    bus_xfer(2, 1, 2'b10, 1, 32'h0000_0030, 32'h1234_5678);
    idle(2);
    for (int j = 0; j < 3; j++) hsel[j] = 1'b0;
    hsel[2] = 1'b1;
    htrans  = 2'b10;
    hwrite  = 1'b1;
    haddr   = 32'h0000_0030;
    @(posedge clk);
    #1;
    hwdata  = 32'hEEEE_EEEE;
    hsel[2] = 1'b0;
    htrans  = 2'b00;
    @(posedge clk);
    #2;
    chk("wait_before_rst", 32'(hreadyout[2]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_hreadyout", 32'(hreadyout[2]), 32'd1);
    chk("arst_hresp", 32'(hresp[2]), 32'd0);
    chk("arst_hrdata", hrdata[2], 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus_xfer(2, 1, 2'b10, 0, 32'h0000_0030, 32'h0);
    bus_xfer(2, 1, 2'b10, 0, 32'h0000_0033, 32'h0);
    idle(2);
    idle(2);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d responses outstanding, required 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
